// File: rtl/sdemux_pkg.sv
// Shared definitions for the registered signed 1-to-2 demultiplexer.
// Optional per-channel transfer counters are enabled with SDEMUX_CNT_EN.
package sdemux_pkg;

  localparam logic ST_EMPTY = 1'b0;
  localparam logic ST_FULL  = 1'b1;

  localparam int unsigned DATAWIDTH_DEF = 8;
  localparam int unsigned CNTWIDTH_DEF  = 16;

  typedef enum logic {
    StEmpty = ST_EMPTY,
    StFull  = ST_FULL
  } slot_state_e;

endpackage

// File: rtl/sdemux_chan_slot.sv
// One-entry output slot: data register, EMPTY/FULL state and load/drain control.
// With SDEMUX_CNT_EN defined it also counts output transfers (wrapping).
module sdemux_chan_slot
  import sdemux_pkg::*;
#(
  parameter int unsigned DATAWIDTH = DATAWIDTH_DEF
`ifdef SDEMUX_CNT_EN
  ,
  parameter int unsigned CNTWIDTH  = CNTWIDTH_DEF
`endif
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        load,
  input  logic signed [DATAWIDTH-1:0] din,
  input  logic                        rdy,
  output logic signed [DATAWIDTH-1:0] dout,
  output logic                        valid
`ifdef SDEMUX_CNT_EN
  ,
  output logic        [CNTWIDTH-1:0]  cnt
`endif
);

  slot_state_e                 state_q;
  logic signed [DATAWIDTH-1:0] data_q;

  // The top only asserts load when the slot is empty or draining this cycle,
  // so a load while FULL always replaces a word that is being consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEmpty;
      data_q  <= '0;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (load) begin
            data_q  <= din;
            state_q <= StFull;
          end
        end
        StFull: begin
          if (load) begin
            data_q <= din;
          end else if (rdy) begin
            state_q <= StEmpty;
          end
        end
      endcase
    end
  end

  assign dout  = data_q;
  assign valid = (state_q == StFull);

`ifdef SDEMUX_CNT_EN
  logic [CNTWIDTH-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (valid && rdy) begin
      cnt_q <= cnt_q + CNTWIDTH'(1);
    end
  end

  assign cnt = cnt_q;
`endif

endmodule

// File: rtl/sdemux1x2_reg.sv
// Registered signed 1-to-2 demux with valid/ready on the input and both outputs.
// Define SDEMUX_CNT_EN to add per-channel output-transfer counters cnt0/cnt1.
module sdemux1x2_reg
  import sdemux_pkg::*;
#(
  parameter int unsigned DATAWIDTH = DATAWIDTH_DEF,
  parameter int unsigned CNTWIDTH  = CNTWIDTH_DEF
) (
  input  logic                        Clk,
  input  logic                        Rst_n,
  input  logic signed [DATAWIDTH-1:0] a,
  input  logic                        sel,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic signed [DATAWIDTH-1:0] d0,
  output logic                        valid0,
  input  logic                        rdy0,
  output logic signed [DATAWIDTH-1:0] d1,
  output logic                        valid1,
  input  logic                        rdy1
`ifdef SDEMUX_CNT_EN
  ,
  output logic        [CNTWIDTH-1:0]  cnt0,
  output logic        [CNTWIDTH-1:0]  cnt1
`endif
);

  if (DATAWIDTH == 0 || CNTWIDTH == 0) begin : g_bad_param
    $error("sdemux1x2_reg: DATAWIDTH and CNTWIDTH must be non-zero");
  end

  logic valid_sel;
  logic rdy_sel;
  logic accept;
  logic load0;
  logic load1;

  // Only the addressed slot can stall the producer.
  assign valid_sel = sel ? valid1 : valid0;
  assign rdy_sel   = sel ? rdy1 : rdy0;
  assign in_ready  = ~valid_sel | rdy_sel;

  assign accept = in_valid & in_ready;
  assign load0  = accept & ~sel;
  assign load1  = accept & sel;

  sdemux_chan_slot #(
    .DATAWIDTH (DATAWIDTH)
`ifdef SDEMUX_CNT_EN
    ,
    .CNTWIDTH  (CNTWIDTH)
`endif
  ) u_slot0 (
    .clk   (Clk),
    .rst_n (Rst_n),
    .load  (load0),
    .din   (a),
    .rdy   (rdy0),
    .dout  (d0),
    .valid (valid0)
`ifdef SDEMUX_CNT_EN
    ,
    .cnt   (cnt0)
`endif
  );

  sdemux_chan_slot #(
    .DATAWIDTH (DATAWIDTH)
`ifdef SDEMUX_CNT_EN
    ,
    .CNTWIDTH  (CNTWIDTH)
`endif
  ) u_slot1 (
    .clk   (Clk),
    .rst_n (Rst_n),
    .load  (load1),
    .din   (a),
    .rdy   (rdy1),
    .dout  (d1),
    .valid (valid1)
`ifdef SDEMUX_CNT_EN
    ,
    .cnt   (cnt1)
`endif
  );

endmodule

// File: tb/tb_sdemux1x2_reg.sv
// Directed bench for sdemux1x2_reg with hand-computed expectations.
// Counter checks are compiled in only when SDEMUX_CNT_EN is defined.
module tb_sdemux1x2_reg;

  localparam int unsigned DW = 8;
`ifdef SDEMUX_CNT_EN
  localparam int unsigned CW = 4;
`else
  localparam int unsigned CW = 16;
`endif

  logic          Clk;
  logic          Rst_n;
  logic [DW-1:0] a;
  logic          sel;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] d0;
  logic          valid0;
  logic          rdy0;
  logic [DW-1:0] d1;
  logic          valid1;
  logic          rdy1;
`ifdef SDEMUX_CNT_EN
  logic [CW-1:0] cnt0;
  logic [CW-1:0] cnt1;
`endif

  int n_vec    = 0;
  int n_miscmp = 0;

  sdemux1x2_reg #(
    .DATAWIDTH (DW),
    .CNTWIDTH  (CW)
  ) u_dut (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .a        (a),
    .sel      (sel),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .d0       (d0),
    .valid0   (valid0),
    .rdy0     (rdy0),
    .d1       (d1),
    .valid1   (valid1),
    .rdy1     (rdy1)
`ifdef SDEMUX_CNT_EN
    ,
    .cnt0     (cnt0),
    .cnt1     (cnt1)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // An unknown select on a presented word is a producer bug.
  always @(negedge Clk) begin
    if (Rst_n === 1'b1 && in_valid === 1'b1) check_eq("sel_known", 32'($isunknown(sel)), 0);
  end

  initial begin
    Rst_n    = 1'b0;
    a        = DW'($urandom);
    sel      = 1'($urandom);
    in_valid = 1'b1;
    rdy0     = 1'($urandom);
    rdy1     = 1'($urandom);

    // Reset with random inputs, including across a clock edge
    #3;
    check_eq("rst_d0", d0, 0);
    check_eq("rst_d1", d1, 0);
    check_eq("rst_valid0", valid0, 0);
    check_eq("rst_valid1", valid1, 0);
    check_eq("rst_in_ready", in_ready, 1);
    #4;
    check_eq("rst_hold_valid0", valid0, 0);
    check_eq("rst_hold_valid1", valid1, 0);
    in_valid = 1'b0;
    rdy0     = 1'b0;
    rdy1     = 1'b0;
    #5 Rst_n = 1'b1;
    #1;
    check_eq("rel_valid0", valid0, 0);
    check_eq("rel_d0", d0, 0);
    tick();

    // Basic steer
    a = 8'hFB; sel = 1'b0; in_valid = 1'b1;
    #1 check_eq("steer0_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check_eq("steer0_d0", d0, 32'h0000_00FB);
    check_eq("steer0_valid0", valid0, 1);
    check_eq("steer0_valid1", valid1, 0);
    a = 8'h7F; sel = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check_eq("steer1_d1", d1, 32'h0000_007F);
    check_eq("steer1_valid1", valid1, 1);
    check_eq("steer1_d0", d0, 32'h0000_00FB);

    // in_ready depends only on the addressed slot, not on in_valid
    sel = 1'b0;
    #1 check_eq("idle_ready_full0", in_ready, 0);

    // Backpressure on channel 0
    a = 8'h03; sel = 1'b0; in_valid = 1'b1;
    #1 check_eq("bp_in_ready", in_ready, 0);
    repeat (10) tick();
    check_eq("bp_d0_hold", d0, 32'h0000_00FB);
    check_eq("bp_valid0_hold", valid0, 1);
    check_eq("bp_in_ready_hold", in_ready, 0);
    rdy0 = 1'b1;
    #1 check_eq("bp_release_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    rdy0     = 1'b0;
    check_eq("bp_d0_new", d0, 32'h0000_0003);
    check_eq("bp_valid0_new", valid0, 1);

    // Drain channel 1; data must persist with valid low
    rdy1 = 1'b1;
    tick();
    rdy1 = 1'b0;
    check_eq("drain1_valid1", valid1, 0);
    check_eq("drain1_d1_kept", d1, 32'h0000_007F);

    // No cross-blocking: channel 0 stalled, channel 1 still accepts
    a = 8'h80; sel = 1'b1; in_valid = 1'b1;
    #1 check_eq("xblk_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check_eq("xblk_d1", d1, 32'h0000_0080);
    check_eq("xblk_valid1", valid1, 1);
    check_eq("xblk_d0", d0, 32'h0000_0003);
    check_eq("xblk_valid0", valid0, 1);

    // Both channels drain on the same edge
    rdy0 = 1'b1; rdy1 = 1'b1;
    tick();
    check_eq("both_drain_valid0", valid0, 0);
    check_eq("both_drain_valid1", valid1, 0);

    // Full-throughput alternating stream
    for (int i = 0; i < 100; i++) begin
      a = DW'(i); sel = i[0]; in_valid = 1'b1;
      #1 check_eq("tp_in_ready", in_ready, 1);
      tick();
      if (i[0]) begin
        check_eq("tp_d1", d1, i);
        check_eq("tp_valid1", valid1, 1);
        check_eq("tp_valid0", valid0, 0);
      end else begin
        check_eq("tp_d0", d0, i);
        check_eq("tp_valid0", valid0, 1);
        check_eq("tp_valid1", valid1, 0);
      end
    end
    in_valid = 1'b0;
    tick();
    check_eq("tp_end_valid0", valid0, 0);
    check_eq("tp_end_valid1", valid1, 0);

    // Asynchronous reset mid-cycle discards a held word
    rdy0 = 1'b0; rdy1 = 1'b0;
    a = 8'h55; sel = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check_eq("pre_arst_valid0", valid0, 1);
    #2 Rst_n = 1'b0;
    #1;
    check_eq("arst_valid0", valid0, 0);
    check_eq("arst_d0", d0, 0);
    check_eq("arst_d1", d1, 0);
    tick();
    #3 Rst_n = 1'b1;
    tick();
    check_eq("post_arst_valid0", valid0, 0);
    check_eq("post_arst_valid1", valid1, 0);

`ifdef SDEMUX_CNT_EN
    // 17 drains on a 4-bit counter wrap to 1
    rdy0 = 1'b1;
    for (int i = 0; i < 17; i++) begin
      a = DW'(i); sel = 1'b0; in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    tick();
    check_eq("cnt0_wrap", cnt0, 1);
    check_eq("cnt1_idle", cnt1, 0);
    rdy1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = DW'(i); sel = 1'b1; in_valid = 1'b1;
      tick();
    end
    #2 Rst_n = 1'b0;
    #1;
    check_eq("cnt0_rst", cnt0, 0);
    check_eq("cnt1_rst", cnt1, 0);
    in_valid = 1'b0;
    tick();
    Rst_n = 1'b1;
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
